// File: rtl/aes_pkg.sv
// Shared AES definitions: byte/word types, the affine constant and the
// FIPS-197 forward S-box table used by the byte-lane substitution logic.
package aes_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  localparam int    LANES    = 4;
  localparam byte_t AFFINE_C = 8'h63;

  // Indexed by the input byte; entry 0 is S(0x00) = AFFINE_C because 0 maps to inverse 0.
  localparam byte_t SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/s_box_if.sv
// Row-in / row-out signal bundle for the S-box word stage, used by benches and
// surrounding datapath glue to group the word bus.
interface s_box_if;
  import aes_pkg::*;

  word_t row_in;
  word_t row_out;

  modport master (output row_in, input row_out);
  modport slave  (input row_in, output row_out);
endinterface

// File: rtl/sbox_byte.sv
// Single-lane AES forward S-box: purely combinational table lookup.
module sbox_byte
  import aes_pkg::*;
(
  input  byte_t in_byte,
  output byte_t out_byte
);

  // NOTE: always_comb assigns out_byte on every path, so no latch can be inferred.
  always_comb begin
    out_byte = SBOX_TABLE[in_byte];
  end

endmodule

// File: rtl/s_box.sv
// AES SubBytes on one 32-bit word: four independent byte lanes feeding a
// single output register, one word per clock with one cycle of latency.
module s_box
  import aes_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  word_t row_in,
  output word_t row_out
);

  word_t sub_word;
  word_t row_out_d;
  word_t row_out_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sbox_byte u_sbox_byte (
      .in_byte  (row_in[8*k +: 8]),
      .out_byte (sub_word[8*k +: 8])
    );
  end

  always_comb begin
    row_out_d = sub_word;
  end

  // NOTE: sequential state uses non-blocking assignments; rst clears the register asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_out_q <= '0;
    end else begin
      row_out_q <= row_out_d;
    end
  end

  assign row_out = row_out_q;

endmodule

// File: tb/tb_s_box.sv
// Directed bench for s_box: reset, known rows, full byte sweep on all lanes,
// back-to-back streaming and an asynchronous mid-stream reset.
module tb_s_box;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fails  = 0;
  byte_t model [256];

  s_box_if bus ();

  s_box dut (
    .clk     (clk),
    .rst     (rst),
    .row_in  (bus.row_in),
    .row_out (bus.row_out)
  );

  always #5 clk = ~clk;

  // Reference S-box built from GF(2^8) arithmetic, independent of the RTL table.
  function automatic byte_t gmul(byte_t a, byte_t b);
    byte_t p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? byte_t'((a << 1) ^ 8'h1b) : byte_t'(a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic byte_t rotl(byte_t v, int n);
    return byte_t'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic byte_t sbox_ref(byte_t x);
    byte_t inv = 8'h00;
    if (x != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, byte_t'(y)) == 8'h01) inv = byte_t'(y);
      end
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic word_t sub_word_ref(word_t w);
    return {model[w[31:24]], model[w[23:16]], model[w[15:8]], model[w[7:0]]};
  endfunction

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input string tag, input word_t v, input word_t exp);
    @(negedge clk);
    bus.row_in = v;
    @(posedge clk);
    #1;
    check(tag, bus.row_out, exp);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = sbox_ref(byte_t'(i));

    rst        = 1'b1;
    bus.row_in = 32'hFFFF_FFFF;
    #1;
    check("reset_before_edge", bus.row_out, 32'h0000_0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_after_edges", bus.row_out, 32'h0000_0000);

    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_release_no_edge", bus.row_out, 32'h0000_0000);

    step("known_row",  32'h0011_2233, 32'h6382_93C3);
    step("spot_a",     32'h530F_10FF, 32'hED76_CA16);
    step("spot_b",     32'h0180_F0C9, 32'h7CCD_8CDD);

    // Output must hold until the next edge even though row_in has moved.
    @(negedge clk);
    bus.row_in = 32'h0000_0000;
    #1;
    check("registered_hold", bus.row_out, 32'h7CCD_8CDD);
    @(posedge clk);
    #1;
    check("zero_bytes", bus.row_out, 32'h6363_6363);

    // Every lane sees all 256 values, each lane with a different permutation,
    // and consecutive words always differ so drops or repeats are caught.
    for (int b = 0; b < 256; b++) begin
      byte_t x;
      word_t w;
      x = byte_t'(b);
      w = {x, x ^ 8'h55, ~x, byte_t'(x + 8'd1)};
      step($sformatf("sweep_%02h", x), w, sub_word_ref(w));
    end

    step("stream_a", 32'hA5A5_5A5A, sub_word_ref(32'hA5A5_5A5A));

    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midstream_reset_async", bus.row_out, 32'h0000_0000);
    rst        = 1'b0;
    bus.row_in = 32'hDEAD_BEEF;
    #1;
    check("midstream_reset_hold", bus.row_out, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("post_reset_load", bus.row_out, 32'h1D95_AEDF);

    step("final_row", 32'hFF00_8001, 32'h1663_CD7C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
